// File: rtl/sram_fifo_pkg.sv
// Shared constants and width helpers for the SRAM-backed FIFO controller.
package sram_fifo_pkg;

    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = 2;

    function automatic int cnt_w(input int aw);
        return aw + 1;
    endfunction

    function automatic int level_w(input int aw);
        return aw + 2;
    endfunction

    function automatic int strb_w(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/sram_fifo_skid.sv
// Two-entry in-order output buffer that catches words returning from the SRAM read port.
module sram_fifo_skid
    import sram_fifo_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DW-1:0]         push_data,
    output logic [DW-1:0]         head_data,
    output logic [SKID_CNT_W-1:0] cnt
);

    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]         e0_q, e0_d, e1_q, e1_d;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        if (clr) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + SKID_CNT_W'(push) - SKID_CNT_W'(pop);
        end
        // e0 is always the head; e1 only ever holds the second-oldest word
        case ({push, pop})
            2'b10: begin
                if (cnt_q == '0) e0_d = push_data;
                else             e1_d = push_data;
            end
            2'b01: e0_d = e1_q;
            2'b11: begin
                if (cnt_q == SKID_CNT_W'(1)) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_ff @(posedge CLK) begin
        e0_q <= e0_d;
        e1_q <= e1_d;
    end

    assign head_data = e0_q;
    assign cnt       = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a 1W/1R SRAM with a 2-entry output skid; 3-cycle fill latency.
// Optional registered occupancy output enabled by defining SRAM_FIFO_CTRL_LEVEL_EN.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 14
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [DW-1:0]          sram_data_w,
    output logic [AW-1:0]          sram_addr_w,
    output logic [strb_w(DW)-1:0]  sram_wstrb,
    output logic                   sram_en_w,
    output logic [AW-1:0]          sram_addr_r,
    output logic                   sram_en_r,
    input  logic [DW-1:0]          sram_data_r
`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [level_w(AW)-1:0] level
`endif
);

    localparam int             CW = cnt_w(AW);
    localparam int             SW = strb_w(DW);
    localparam logic [CW-1:0]  DP = CW'(1) << AW;

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         sram_cnt_q, sram_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [SKID_CNT_W-1:0] skid_cnt;
    logic [2:0]            skid_load;
    logic                  in_fire, out_fire, rd_issue, skid_push;

    // Issue decision uses only registered count, so a word is never read in its write cycle
    always_comb begin
        in_ready  = !RST && !flush && (sram_cnt_q < DP);
        in_fire   = in_valid && in_ready;
        out_valid = (skid_cnt != '0);
        out_fire  = out_valid && out_ready;
        skid_load = {1'b0, skid_cnt} + {2'b00, rd_pend_q} - {2'b00, out_fire};
        rd_issue  = (sram_cnt_q != '0) && !flush && (skid_load < 3'(SKID_DEPTH));
        skid_push = rd_pend_q && !flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        sram_cnt_d = sram_cnt_q;
        rd_pend_d  = 1'b0;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            sram_cnt_d = '0;
        end else begin
            if (in_fire)  wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_issue) rd_ptr_d = rd_ptr_q + AW'(1);
            sram_cnt_d = sram_cnt_q + CW'(in_fire) - CW'(rd_issue);
            rd_pend_d  = rd_issue;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    assign sram_en_w   = in_fire;
    assign sram_addr_w = wr_ptr_q;
    assign sram_data_w = in_data;
    assign sram_wstrb  = {SW{in_fire}};
    assign sram_en_r   = rd_issue;
    assign sram_addr_r = rd_ptr_q;

    sram_fifo_skid #(
        .DW(DW)
    ) u_skid (
        .CLK       (CLK),
        .RST       (RST),
        .clr       (flush),
        .push      (skid_push),
        .pop       (out_fire),
        .push_data (sram_data_r),
        .head_data (out_data),
        .cnt       (skid_cnt)
    );

`ifdef SRAM_FIFO_CTRL_LEVEL_EN
    localparam int LW = level_w(AW);

    logic [LW-1:0]         level_q, level_d;
    logic [SKID_CNT_W-1:0] skid_cnt_d;

    // Built from next-state values so level tracks the queue with no extra lag
    always_comb begin
        if (flush) skid_cnt_d = '0;
        else       skid_cnt_d = skid_cnt + SKID_CNT_W'(skid_push) - SKID_CNT_W'(out_fire);
        level_d = LW'(sram_cnt_d) + LW'(rd_pend_d) + LW'(skid_cnt_d);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) level_q <= '0;
        else     level_q <= level_d;
    end

    assign level = level_q;
`endif

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits.
REQ-002 SHALL have parameter AW, default 14: SRAM address width; FIFO SRAM depth DP = 2**AW.
REQ-003 SHALL have port CLK, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port flush, input, 1: synchronous clear of all queue state.
REQ-006 SHALL have port in_valid, input, 1: producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1: controller can accept a word.
REQ-008 SHALL have port in_data, input, DW: write word.
REQ-009 SHALL have port out_valid, output, 1: out_data holds the head word.
REQ-010 SHALL have port out_ready, input, 1: consumer takes the head word.
REQ-011 SHALL have port out_data, output, DW: head word.
REQ-012 SHALL have ports sram_data_w (output, DW), sram_addr_w (output, AW), sram_wstrb (output, (DW+7)/8) and sram_en_w (output, 1), which drive the SRAM write port.
REQ-013 SHALL have ports sram_addr_r (output, AW), sram_en_r (output, 1) and sram_data_r (input, DW); the SRAM returns data one cycle after sram_en_r and holds it while sram_en_r is low.

Function
REQ-014 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-015 SHALL drive in_ready = !flush & (sram_cnt < DP), where sram_cnt (AW+1 bits) counts words written to the SRAM but not yet read.
REQ-016 SHALL, on in_fire, assert sram_en_w with sram_addr_w = wr_ptr, sram_data_w = in_data and sram_wstrb all ones, then increment wr_ptr modulo DP.
REQ-017 SHALL issue a read (sram_en_r = 1, sram_addr_r = rd_ptr, then increment rd_ptr modulo DP) when sram_cnt > 0, !flush, and (skid_cnt + rd_pend - out_fire) < 2.
REQ-018 SHALL compute the read-issue decision only from registered sram_cnt, so that a word written in cycle N becomes readable no earlier than cycle N+1; no read-during-write hazard is possible.
REQ-019 SHALL register rd_pend = sram_en_r and, in the cycle rd_pend = 1, capture sram_data_r into a 2-entry output skid buffer at the next edge.
REQ-020 SHALL drive out_valid = (skid_cnt > 0) and out_data = skid head; the skid buffer is in-order.
REQ-021 SHALL give a latency of exactly 3 cycles into an empty FIFO: a word accepted in cycle N has out_valid asserted in cycle N+3.
REQ-022 SHALL sustain one word per cycle in steady state when in_valid = out_ready = 1.
REQ-023 SHALL, in the same cycle, apply sram_cnt += in_fire - sram_en_r; when full, a simultaneous read frees space only from the next cycle.
REQ-024 SHALL wrap wr_ptr and rd_ptr from DP-1 to 0 with no lost or duplicated word.
REQ-025 SHALL, on flush, clear at the next edge wr_ptr, rd_ptr, sram_cnt, rd_pend and skid_cnt; data returning from a read in flight is discarded; flush overrides a simultaneous in_valid or out_ready.
REQ-026 SHALL never assert sram_en_w and sram_en_r with an issue for an address not yet written.

Reset
REQ-027 SHALL, while RST = 1, hold pointers, sram_cnt, rd_pend and skid_cnt at 0, so that out_valid = 0, sram_en_w = 0 and sram_en_r = 0.
REQ-028 SHALL, while RST = 1, hold in_ready = 0; in_ready equals 1 in the first cycle after RST deasserts if flush = 0.
REQ-029 SHALL leave SRAM contents untouched by RST; on reset mid-operation, all queued words are lost.

Configuration
REQ-030 SHALL, with SRAM_FIFO_CTRL_LEVEL_EN defined, add output level (AW+2 bits) = sram_cnt + rd_pend + skid_cnt, registered, reset 0.
REQ-031 SHALL, without SRAM_FIFO_CTRL_LEVEL_EN, have no level port and no behaviour difference.

Structure
REQ-032 SHALL place the skid depth constant (2) and the pointer/count width helper functions in shared package sram_fifo_pkg.
REQ-033 SHALL implement the 2-entry in-order output buffer as sub-module sram_fifo_skid (push, pop, data, cnt).

Verification
REQ-034 SHALL cover single word: after reset, write 0xA5A5A5A5 in cycle 0 -> out_valid in cycle 3 with out_data = 0xA5A5A5A5, then empty.
REQ-035 SHALL cover streaming: 64 words (0..63) with out_ready = 1 -> in-order output, one per cycle after the 3-cycle fill, in_ready never low.
REQ-036 SHALL cover full: AW = 4, out_ready = 0, push 20 words -> 18 accepted (16 SRAM + 2 skid), then in_ready = 0; one pop -> in_ready returns to 1 within 2 cycles.
REQ-037 SHALL cover wrap: AW = 4, 100 words with random out_ready -> exact order preserved across pointer wrap.
REQ-038 SHALL cover flush while a read is in flight and skid_cnt = 2 -> next cycle out_valid = 0, and level = 0 when SRAM_FIFO_CTRL_LEVEL_EN is defined; the next written word is the next output.
REQ-039 SHALL cover RST asserted mid-stream -> outputs cleared immediately, and after release the first new word appears in cycle N+3.
